// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter and its round-robin
// selector: arbiter state encoding, default sizing constants and the grant
// index width calculation.
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

   localparam int DEF_N_REQ     = 4;
   localparam int DEF_DSIZE     = 8;
   localparam int DEF_MAX_BURST = 8;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int idw_calc(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) begin
         return 1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req starting at ptr+1 and
// wrapping modulo N; the entry at ptr itself is checked last, so the most
// recent owner has the lowest priority.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  index of the previous winner (must be < N)
//   found out 1   at least one request is set
//   idx   out IW  winning index (0 when found is low)
// ---------------------------------------------------------------------------
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N  = DEF_N_REQ,
   parameter int IW = 2
)(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   // (p + k) mod N for p < N and 1 <= k <= N; one subtraction covers the wrap.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
      logic [IW:0] s;
      s = {1'b0, p} + (IW+1)'(k);
      if (s >= (IW+1)'(N)) begin
         s = s - (IW+1)'(N);
      end else begin
         s = s;
      end
      return s[IW-1:0];
   endfunction

   // First set request in rotating order after ptr.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[wrap_add(ptr, k)]) begin
            found = 1'b1;
            idx   = wrap_add(ptr, k);
         end else begin
            // an earlier hit in the rotation keeps priority
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of the async FIFO (wclk side) among N_REQ
// producers. Round-robin grants are locked for a whole packet (until the
// beat flagged last) or MAX_BURST beats, so a source's beats land
// contiguously. One IDLE bubble cycle separates consecutive grants.
//
// Optional build macro FIFO_WR_ARB_TAG_EN: when defined, fifo_wdata carries
// {grant_id, payload} (IDW+DSIZE bits) so the read side can demultiplex by
// source; otherwise fifo_wdata is the payload only (DSIZE bits).
//
// Ports:
//   wclk        in  1            write clock (FIFO write side)
//   wrst_n      in  1            asynchronous active-low reset
//   req_valid   in  N_REQ        per-requester beat valid
//   req_last    in  N_REQ        per-requester last beat of packet
//   req_data    in  N_REQ*DSIZE  payloads, requester i at [i*DSIZE +: DSIZE]
//   req_ready   out N_REQ        beat accepted this cycle (owner only, !full)
//   fifo_wfull  in  1            FIFO registered full flag
//   fifo_winc   out 1            FIFO write strobe
//   fifo_wdata  out OW           FIFO write data
//   grant_id    out IDW          current/last owner index
//   busy        out 1            a grant is held
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int N_REQ     = DEF_N_REQ,
   parameter  int DSIZE     = DEF_DSIZE,
   parameter  int MAX_BURST = DEF_MAX_BURST,
   localparam int IDW       = idw_calc(N_REQ),
`ifdef FIFO_WR_ARB_TAG_EN
   localparam int OW        = IDW + DSIZE
`else
   localparam int OW        = DSIZE
`endif
)(
   input  logic                   wclk,
   input  logic                   wrst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_last,
   input  logic [N_REQ*DSIZE-1:0] req_data,
   output logic [N_REQ-1:0]       req_ready,
   input  logic                   fifo_wfull,
   output logic                   fifo_winc,
   output logic [OW-1:0]          fifo_wdata,
   output logic [IDW-1:0]         grant_id,
   output logic                   busy
);

   localparam int BCW = $clog2(MAX_BURST + 1);

   arb_state_t       state_r;
   logic [IDW-1:0]   rr_ptr_r;
   logic [BCW-1:0]   beat_cnt_r;

   logic             pick_found_s;
   logic [IDW-1:0]   pick_idx_s;
   logic             sel_valid_s;
   logic             sel_last_s;
   logic [DSIZE-1:0] sel_data_s;
   logic             accept_s;
   logic             release_s;

   rr_pick #(
      .N  (N_REQ),
      .IW (IDW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_r),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   assign sel_valid_s = req_valid[grant_id];
   assign sel_last_s  = req_last[grant_id];
   assign sel_data_s  = req_data[grant_id*DSIZE +: DSIZE];

   // The full flag gates the accept directly, so a write never coincides with wfull.
   assign accept_s  = (state_r == ARB_BURST) & sel_valid_s & ~fifo_wfull;
   assign release_s = accept_s & (sel_last_s | (beat_cnt_r == BCW'(MAX_BURST - 1)));

   assign fifo_winc = accept_s;
`ifdef FIFO_WR_ARB_TAG_EN
   assign fifo_wdata = {grant_id, sel_data_s};
`else
   assign fifo_wdata = sel_data_s;
`endif

   // Only the owner sees ready, and only while the FIFO has room.
   always_comb begin
      req_ready = '0;
      if (state_r == ARB_BURST) begin
         req_ready[grant_id] = ~fifo_wfull;
      end else begin
         req_ready = '0;
      end
   end

   // Arbitration FSM: grant selection, burst counting and release.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_r    <= ARB_IDLE;
         grant_id   <= '0;
         rr_ptr_r   <= IDW'(N_REQ - 1);
         beat_cnt_r <= '0;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            ARB_IDLE: begin
               if (pick_found_s) begin
                  grant_id   <= pick_idx_s;
                  state_r    <= ARB_BURST;
                  busy       <= 1'b1;
                  beat_cnt_r <= '0;
               end else begin
                  busy <= 1'b0;
               end
            end
            ARB_BURST: begin
               if (release_s) begin
                  state_r    <= ARB_IDLE;
                  busy       <= 1'b0;
                  rr_ptr_r   <= grant_id;
                  beat_cnt_r <= '0;
               end else if (accept_s) begin
                  beat_cnt_r <= beat_cnt_r + BCW'(1);
               end else begin
                  // stalled on full or idle owner: hold grant and count
                  beat_cnt_r <= beat_cnt_r;
               end
            end
            default: begin
               state_r <= ARB_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (N_REQ=4, DSIZE=8, MAX_BURST=8).
// A cycle table covers reset, single-source packets, full stall and
// round-robin order; queue-driven sequences cover multi-grant ordering,
// MAX_BURST release, long full stalls, reset mid-burst and tagging.
// Expected writes go into a scoreboard queue and are compared on fifo_winc.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N   = 4;
   localparam int DS  = 8;
   localparam int MB  = 8;
   localparam int IDW = 2;
`ifdef FIFO_WR_ARB_TAG_EN
   localparam int OW  = IDW + DS;
`else
   localparam int OW  = DS;
`endif

   logic            wclk = 1'b0;
   logic            wrst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DS-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_wfull;
   logic            fifo_winc;
   logic [OW-1:0]   fifo_wdata;
   logic [IDW-1:0]  grant_id;
   logic            busy;

   fifo_wr_arbiter #(.N_REQ(N), .DSIZE(DS), .MAX_BURST(MB)) dut (
      .wclk       (wclk),
      .wrst_n     (wrst_n),
      .req_valid  (req_valid),
      .req_last   (req_last),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .fifo_wfull (fifo_wfull),
      .fifo_winc  (fifo_winc),
      .fifo_wdata (fifo_wdata),
      .grant_id   (grant_id),
      .busy       (busy)
   );

   always #5 wclk = ~wclk;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DS-1:0]  data;
   } wr_t;

   typedef struct {
      logic [3:0] rv;
      logic [3:0] rl;
      logic [7:0] d0;
      logic       wf;
      logic [3:0] e_rdy;
      logic       e_winc;
      logic [1:0] e_g;
      logic       e_b;
   } vec_t;

   wr_t        exp_q[$];
   logic [8:0] src_q [N][$];   // {last, data} per requester
   vec_t       tbl [10];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   wr_seen = 0;
   int   last_wr_cyc = -1;
   int   full_left = 0;
   bit   full_arm = 1'b0;
   logic rst_lvl = 1'b0;

   logic [N-1:0]    prev_v = '0;
   logic [N-1:0]    prev_r = '0;
   logic [N-1:0]    prev_l = '0;
   logic [N*DS-1:0] prev_d = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pending();
      int p;
      p = exp_q.size();
      for (int i = 0; i < N; i++) p += src_q[i].size();
      return p;
   endfunction

   // One clock cycle: drive at negedge, check 1 ns later, before the next posedge.
   task automatic cycle(input int ti);
      wr_t           e;
      logic [OW-1:0] ew;
      @(negedge wclk);
      wrst_n = rst_lvl;
      if (ti >= 0) begin
         req_valid  = tbl[ti].rv;
         req_last   = tbl[ti].rl;
         req_data   = {8'hE3, 8'hE2, 8'hE1, tbl[ti].d0};
         fifo_wfull = tbl[ti].wf;
      end else begin
         fifo_wfull = 1'b0;
         if (full_arm && wr_seen == 5 && full_left > 0) begin
            fifo_wfull = 1'b1;
            full_left--;
         end
         for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
               req_valid[i]        = 1'b1;
               req_last[i]         = src_q[i][0][8];
               req_data[i*DS +: DS] = src_q[i][0][7:0];
            end else begin
               req_valid[i]        = 1'b0;
               req_last[i]         = 1'b0;
               req_data[i*DS +: DS] = 8'h00;
            end
         end
      end
      #1;
      // requester protocol: data/last stable while valid and not accepted
      for (int i = 0; i < N; i++) begin
         if (prev_v[i] && !prev_r[i] && req_valid[i])
            chk("req_hold", {23'd0, req_last[i], req_data[i*DS +: DS]},
                {23'd0, prev_l[i], prev_d[i*DS +: DS]});
      end
      if (!wrst_n) begin
         chk("rst_busy",  {31'd0, busy}, 32'd0);
         chk("rst_grant", {30'd0, grant_id}, 32'd0);
         chk("rst_ready", {28'd0, req_ready}, 32'd0);
         chk("rst_winc",  {31'd0, fifo_winc}, 32'd0);
      end else if (ti >= 0) begin
         chk("tbl_ready", {28'd0, req_ready}, {28'd0, tbl[ti].e_rdy});
         chk("tbl_winc",  {31'd0, fifo_winc}, {31'd0, tbl[ti].e_winc});
         chk("tbl_grant", {30'd0, grant_id}, {30'd0, tbl[ti].e_g});
         chk("tbl_busy",  {31'd0, busy}, {31'd0, tbl[ti].e_b});
         if (tbl[ti].e_winc)
            exp_q.push_back('{id: tbl[ti].e_g,
                              data: (tbl[ti].e_g == 2'd0) ? tbl[ti].d0 : (8'hE0 | {6'd0, tbl[ti].e_g})});
      end else begin
         // queue-driven cycles are checked through the scoreboard
      end
      if (wrst_n && fifo_wfull) begin
         chk("full_winc",  {31'd0, fifo_winc}, 32'd0);
         chk("full_ready", {28'd0, req_ready}, 32'd0);
      end
      if (fifo_winc) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got id %0d data 0x%0h, expected no write (cycle %0d)",
                     grant_id, fifo_wdata, cyc);
         end else begin
            e = exp_q.pop_front();
`ifdef FIFO_WR_ARB_TAG_EN
            ew = {e.id, e.data};
`else
            ew = e.data;
`endif
            chk("wr_id",   {30'd0, grant_id}, {30'd0, e.id});
            chk("wr_data", 32'(fifo_wdata), 32'(ew));
         end
         wr_seen++;
         last_wr_cyc = cyc;
      end
      if (ti < 0) begin
         for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      prev_v = req_valid;
      prev_r = req_ready;
      prev_l = req_last;
      prev_d = req_data;
      cyc++;
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) src_q[i].delete();
      exp_q.delete();
      rst_lvl = 1'b0;
      cycle(-1);
      cycle(-1);
      rst_lvl = 1'b1;
      cyc = 0;
      wr_seen = 0;
      last_wr_cyc = -1;
   endtask

   // Run queue-driven cycles until everything is written, bounded by budget.
   task automatic run(input string name, input int budget);
      int n;
      n = 0;
      while (pending() > 0 && n < budget) begin
         cycle(-1);
         n++;
      end
      chk({name, "_drained"}, 32'(pending()), 32'd0);
      cycle(-1);
      cycle(-1);
      chk({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      wrst_n     = 1'b0;
      req_valid  = '0;
      req_last   = '0;
      req_data   = '0;
      fifo_wfull = 1'b0;

      //          rv       rl       d0     wf    e_rdy    winc  g     busy
      tbl[0] = '{4'b0001, 4'b0000, 8'h01, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[1] = '{4'b0001, 4'b0000, 8'h01, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[2] = '{4'b0001, 4'b0000, 8'h02, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[3] = '{4'b0001, 4'b0001, 8'h03, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[4] = '{4'b0011, 4'b0011, 8'h04, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[5] = '{4'b0011, 4'b0011, 8'h04, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1};
      tbl[6] = '{4'b0011, 4'b0011, 8'h04, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
      tbl[7] = '{4'b0001, 4'b0001, 8'h04, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0};
      tbl[8] = '{4'b0001, 4'b0001, 8'h04, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      tbl[9] = '{4'b0000, 4'b0000, 8'h04, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};

      // reset values, then single source + full stall + round robin from the table
      do_reset();
      for (int t = 0; t < 10; t++) cycle(t);
      chk("tbl_drained", 32'(exp_q.size()), 32'd0);

      // all four requesters, 2-beat packets: order 0,1,2,3 with one bubble each
      do_reset();
      for (int i = 0; i < N; i++) begin
         src_q[i].push_back({1'b0, 8'(8'h10 * i + 1)});
         src_q[i].push_back({1'b1, 8'(8'h10 * i + 2)});
         exp_q.push_back('{id: 2'(i), data: 8'(8'h10 * i + 1)});
         exp_q.push_back('{id: 2'(i), data: 8'(8'h10 * i + 2)});
      end
      run("rr4", 60);
      chk("rr4_writes", 32'(wr_seen), 32'd8);
      chk("rr4_last_cycle", 32'(last_wr_cyc), 32'd11);

      // MAX_BURST: req1 streams 12 beats, req2 waits and gets the port after 8
      do_reset();
      for (int k = 1; k <= 12; k++) src_q[1].push_back({(k == 12), 8'(8'h40 + k)});
      src_q[2].push_back({1'b0, 8'h81});
      src_q[2].push_back({1'b1, 8'h82});
      for (int k = 1; k <= 8; k++) exp_q.push_back('{id: 2'd1, data: 8'(8'h40 + k)});
      exp_q.push_back('{id: 2'd2, data: 8'h81});
      exp_q.push_back('{id: 2'd2, data: 8'h82});
      for (int k = 9; k <= 12; k++) exp_q.push_back('{id: 2'd1, data: 8'(8'h40 + k)});
      run("maxburst", 80);
      chk("maxburst_writes", 32'(wr_seen), 32'd14);

      // FIFO full for 3 cycles after beat 5 of an 18-word stream
      do_reset();
      for (int k = 1; k <= 18; k++) begin
         src_q[0].push_back({(k == 18), 8'(8'hC0 + k)});
         exp_q.push_back('{id: 2'd0, data: 8'(8'hC0 + k)});
      end
      full_arm  = 1'b1;
      full_left = 3;
      run("full", 80);
      full_arm = 1'b0;
      chk("full_writes", 32'(wr_seen), 32'd18);
      chk("full_stall_used", 32'(full_left), 32'd0);

      // reset in BURST after 2 of 4 beats; next grant starts at index 0
      do_reset();
      for (int k = 1; k <= 4; k++) src_q[2].push_back({(k == 4), 8'(8'h20 + k)});
      exp_q.push_back('{id: 2'd2, data: 8'h21});
      exp_q.push_back('{id: 2'd2, data: 8'h22});
      for (int n = 0; n < 20 && wr_seen < 2; n++) cycle(-1);
      chk("mid_writes", 32'(wr_seen), 32'd2);
      rst_lvl = 1'b0;
      cycle(-1);
      do_reset();
      src_q[0].push_back({1'b1, 8'h66});
      src_q[2].push_back({1'b1, 8'h77});
      exp_q.push_back('{id: 2'd0, data: 8'h66});
      exp_q.push_back('{id: 2'd2, data: 8'h77});
      run("after_rst", 30);

      // requester 3 writing 0xA5: tagged 0x3A5, untagged 0xA5
      do_reset();
      src_q[3].push_back({1'b1, 8'hA5});
      exp_q.push_back('{id: 2'd3, data: 8'hA5});
      run("tag", 20);
      chk("tag_writes", 32'(wr_seen), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
